// File: rtl/bar_stream_fifo_if.sv
// bar valid/ready stream bundle: data, valid, ready.
// master drives data/valid and samples ready; slave does the reverse.
interface bar_stream_fifo_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/bar_stream_fifo.sv
// First-word-fall-through FIFO decoupling a bar stream producer and consumer.
// Ports: clk, rst (sync, active-high), in_bus (slave), out_bus (master),
// count (occupancy 0..DEPTH), xfer_count (beats delivered since reset).
module bar_stream_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    parameter  int CW    = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int NW    = AW + 1
) (
    input  logic                clk,
    input  logic                rst,
    bar_stream_fifo_if.slave    in_bus,
    bar_stream_fifo_if.master   out_bus,
    output logic [NW-1:0]       count,
    output logic [CW-1:0]       xfer_count
);
    localparam logic [NW-1:0] FULL = NW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [NW-1:0]    r_count;
    logic [CW-1:0]    r_xfer;

    logic w_in_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;

    // Ready ignores out_ready on purpose: a full FIFO never accepts,
    // even when a pop happens on the same edge.
    assign w_in_ready  = !rst && (r_count != FULL);
    assign w_out_valid = (r_count != '0);
    assign w_push      = in_bus.valid && w_in_ready;
    // rst gates the pop so a handshake during reset is ignored.
    assign w_pop       = !rst && w_out_valid && out_bus.ready;

    assign in_bus.ready  = w_in_ready;
    assign out_bus.valid = w_out_valid;
    assign out_bus.data  = r_mem[r_rd_ptr];
    assign count         = r_count;
    assign xfer_count    = r_xfer;

    // Storage is not reset; w_push is already low during reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_bus.data;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_xfer   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_xfer   <= r_xfer + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end
endmodule
